// File: rtl/fp_pkg.sv
// Shared floating-point constants and field layout for the FPU datapath.
// Defaults describe IEEE single precision.
package fp_pkg;

    localparam int FLOAT_SIZE    = 32;
    localparam int EXPONENT_SIZE = 8;
    localparam int MANTISSA_SIZE = 23;
    localparam int BIAS          = 127;

    typedef struct packed {
        logic                     sign;
        logic [EXPONENT_SIZE-1:0] exponent;
        logic [MANTISSA_SIZE-1:0] mantissa;
    } fp_t;

endpackage

// File: rtl/float_mult_comb.sv
// Combinational float multiply: truncating mantissa product plus wrapping
// exponent arithmetic with carry/borrow flags. Operands assumed normalized.
module float_mult_comb
    import fp_pkg::*;
#(
    parameter int FLOAT_W = FLOAT_SIZE,
    parameter int EXP_W   = EXPONENT_SIZE,
    parameter int MANT_W  = MANTISSA_SIZE,
    parameter int BIAS_V  = BIAS
) (
    input  logic [FLOAT_W-1:0] a,
    input  logic [FLOAT_W-1:0] b,
    output logic [FLOAT_W-1:0] out,
    output logic               overflow,
    output logic               underflow,
    output logic               inexact
);

    localparam int PROD_W = 2 * (MANT_W + 1);
    localparam logic [EXP_W-1:0] BIAS_E = BIAS_V[EXP_W-1:0];

    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [PROD_W-1:0] w_op_a, w_op_b, w_prod;
    logic              w_norm;
    logic [MANT_W-1:0] w_mant;
    logic              w_inexact;
    logic [EXP_W-1:0]  w_s1, w_s2, w_eo;
    logic              w_c1, w_borrow, w_c2;

    assign w_ea = a[FLOAT_W-2 -: EXP_W];
    assign w_eb = b[FLOAT_W-2 -: EXP_W];

    // Operands widened to the full product width so no bits are lost.
    assign w_op_a = {{(MANT_W+1){1'b0}}, 1'b1, a[MANT_W-1:0]};
    assign w_op_b = {{(MANT_W+1){1'b0}}, 1'b1, b[MANT_W-1:0]};
    assign w_prod = w_op_a * w_op_b;
    assign w_norm = w_prod[PROD_W-1];

    assign w_mant    = w_norm ? w_prod[2*MANT_W:MANT_W+1] : w_prod[2*MANT_W-1:MANT_W];
    assign w_inexact = w_norm ? (|w_prod[MANT_W:0]) : (|w_prod[MANT_W-1:0]);

    // One extra MSB on each step captures the carry or borrow.
    assign {w_c1, w_s1}     = {1'b0, w_ea} + {1'b0, w_eb};
    assign {w_borrow, w_s2} = {1'b0, w_s1} - {1'b0, BIAS_E};
    assign {w_c2, w_eo}     = {1'b0, w_s2} + {{EXP_W{1'b0}}, w_norm};

    assign out       = {a[FLOAT_W-1] ^ b[FLOAT_W-1], w_eo, w_mant};
    assign overflow  = w_c1 | w_c2;
    assign underflow = w_borrow;
    assign inexact   = w_inexact;

endmodule

// File: rtl/float_mult_reg.sv
// Floating-point multiplier with a single registered output stage.
// Result and flags load on in_valid; out_valid follows in_valid by one cycle.
module float_mult_reg
    import fp_pkg::*;
#(
    parameter int FLOAT_SIZE    = fp_pkg::FLOAT_SIZE,
    parameter int EXPONENT_SIZE = fp_pkg::EXPONENT_SIZE,
    parameter int MANTISSA_SIZE = fp_pkg::MANTISSA_SIZE,
    parameter int BIAS          = fp_pkg::BIAS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    output logic                  out_valid,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);

    logic [FLOAT_SIZE-1:0] w_out;
    logic                  w_overflow, w_underflow, w_inexact;

    logic [FLOAT_SIZE-1:0] r_out;
    logic                  r_out_valid, r_overflow, r_underflow, r_inexact;

    float_mult_comb #(
        .FLOAT_W (FLOAT_SIZE),
        .EXP_W   (EXPONENT_SIZE),
        .MANT_W  (MANTISSA_SIZE),
        .BIAS_V  (BIAS)
    ) u_comb (
        .a         (a),
        .b         (b),
        .out       (w_out),
        .overflow  (w_overflow),
        .underflow (w_underflow),
        .inexact   (w_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out       <= w_out;
                r_overflow  <= w_overflow;
                r_underflow <= w_underflow;
                r_inexact   <= w_inexact;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_float_mult_reg.sv
// Testbench for float_mult_reg: directed cases from the FP32 rules plus
// random operands checked against an integer-arithmetic reference model.
module tb_float_mult_reg;
    import fp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        d_out_valid;
    logic [31:0] d_out;
    logic        d_overflow, d_underflow, d_inexact;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_out;
    logic        exp_vld, exp_ov, exp_un, exp_ix;

    float_mult_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (d_out_valid),
        .out       (d_out),
        .overflow  (d_overflow),
        .underflow (d_underflow),
        .inexact   (d_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level reading of the multiply rules using plain integers.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] mo, output logic ov,
                                  output logic un, output logic ix);
        fp_t fa, fb;
        longint unsigned sa, sb, p;
        int n, s1, s2, e3;
        logic [22:0] mant;
        fa = ma;
        fb = mb;
        sa = 64'h800000 + longint'(fa.mantissa);
        sb = 64'h800000 + longint'(fb.mantissa);
        p  = sa * sb;
        n  = (p >= 64'h8000_0000_0000) ? 1 : 0;
        if (n == 1) begin
            mant = 23'((p / 64'd16777216) % 64'd8388608);
            ix   = (p % 64'd16777216) != 0;
        end else begin
            mant = 23'((p / 64'd8388608) % 64'd8388608);
            ix   = (p % 64'd8388608) != 0;
        end
        s1 = int'(fa.exponent) + int'(fb.exponent);
        ov = (s1 >= 256);
        s1 = s1 % 256;
        un = (s1 < 127);
        s2 = (s1 - 127 + 256) % 256;
        e3 = s2 + n;
        if (e3 >= 256) ov = 1'b1;
        mo = {fa.sign ^ fb.sign, 8'(e3 % 256), mant};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"}, d_out, exp_out);
        chk({tag, ".out_valid"}, {31'b0, d_out_valid}, {31'b0, exp_vld});
        chk({tag, ".overflow"}, {31'b0, d_overflow}, {31'b0, exp_ov});
        chk({tag, ".underflow"}, {31'b0, d_underflow}, {31'b0, exp_un});
        chk({tag, ".inexact"}, {31'b0, d_inexact}, {31'b0, exp_ix});
    endtask

    task automatic apply(input logic [31:0] ta, input logic [31:0] tb2, input logic v,
                         input string tag);
        @(negedge clk);
        a        = ta;
        b        = tb2;
        in_valid = v;
        vectors++;
        if (v) model(ta, tb2, exp_out, exp_ov, exp_un, exp_ix);
        exp_vld = v;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        exp_out  = '0;
        exp_vld  = 1'b0;
        exp_ov   = 1'b0;
        exp_un   = 1'b0;
        exp_ix   = 1'b0;
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        apply(32'h3F800000, 32'h3F800000, 1'b1, "one_x_one");
        chk("one_x_one.const", d_out, 32'h3F800000);
        apply(32'h3FC00000, 32'h3FC00000, 1'b1, "1p5_sq");
        chk("1p5_sq.const", d_out, 32'h40100000);
        chk("1p5_sq.inexact0", {31'b0, d_inexact}, 32'd0);
        apply(32'hC0000000, 32'h40400000, 1'b1, "neg2_x_3");
        chk("neg2_x_3.const", d_out, 32'hC0C00000);
        apply(32'h3F800001, 32'h3F800001, 1'b1, "lsb_sq");
        chk("lsb_sq.const", d_out, 32'h3F800002);
        chk("lsb_sq.inexact1", {31'b0, d_inexact}, 32'd1);
        apply(32'h7F000000, 32'h7F000000, 1'b1, "exp_wrap");
        chk("exp_wrap.const", d_out, 32'h3E800000);
        chk("exp_wrap.ovf1", {31'b0, d_overflow}, 32'd1);
        apply(32'h00800000, 32'h00800000, 1'b1, "exp_borrow");
        chk("exp_borrow.const", d_out, 32'h41800000);
        chk("exp_borrow.unf1", {31'b0, d_underflow}, 32'd1);

        apply(32'h40490FDB, 32'hC1200000, 1'b0, "hold");
        chk("hold.const", d_out, 32'h41800000);

        // Asynchronous reset between clock edges discards the held result.
        #2;
        rst_n = 1'b0;
        #1;
        exp_out = '0;
        exp_vld = 1'b0;
        exp_ov  = 1'b0;
        exp_un  = 1'b0;
        exp_ix  = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h3FC00000, 32'h40000000, 1'b0, "post_rst_idle");
        apply(32'h3FC00000, 32'h40000000, 1'b1, "post_rst_first");
        chk("post_rst_first.const", d_out, 32'h40400000);

        for (int i = 0; i < 80; i++) begin
            apply($urandom, $urandom, ($urandom_range(0, 3) != 0), "rand");
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
